// File: rtl/gpio_ctrl_pkg.sv
// gpio_ctrl_pkg: register map and bus width shared by the GPIO controller
package gpio_ctrl_pkg;
  localparam int GPIO_DW = 32;
  localparam logic [2:0] GPIO_ADDR_OUT     = 3'd0;
  localparam logic [2:0] GPIO_ADDR_DIR     = 3'd1;
  localparam logic [2:0] GPIO_ADDR_IN      = 3'd2;
  localparam logic [2:0] GPIO_ADDR_RISE_EN = 3'd3;
  localparam logic [2:0] GPIO_ADDR_FALL_EN = 3'd4;
  localparam logic [2:0] GPIO_ADDR_STATUS  = 3'd5;
  localparam logic [2:0] GPIO_ADDR_SET     = 3'd6;
  localparam logic [2:0] GPIO_ADDR_CLR     = 3'd7;
endpackage

// File: rtl/gpio_sync_edge.sv
// gpio_sync_edge: one-pin synchroniser chain plus prev flop giving rise/fall pulses
module gpio_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic resetn,
  input  logic d,
  output logic sync,
  output logic rise,
  output logic fall
);
  logic [SYNC_STAGES-1:0] chain;
  logic prev;
  always_ff @(posedge clk) begin
    if (!resetn) begin
      chain <= '0;
      prev  <= 1'b0;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], d};
      prev  <= chain[SYNC_STAGES-1];
    end
  end
  assign sync = chain[SYNC_STAGES-1];
  assign rise = sync & ~prev;
  assign fall = ~sync & prev;
endmodule

// File: rtl/gpio_ctrl.sv
// gpio_ctrl: bidirectional GPIO with synchronised inputs and W1C edge interrupts.
// Define GPIO_CTRL_SET_CLR_EN to enable atomic SET/CLR writes to OUT.
module gpio_ctrl
  import gpio_ctrl_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               wr_en,
  input  logic               rd_en,
  input  logic [2:0]         addr,
  input  logic [GPIO_DW-1:0] wr_data,
  output logic [GPIO_DW-1:0] rd_data,
  input  logic [WIDTH-1:0]   gpio_in,
  output logic [WIDTH-1:0]   gpio_out,
  output logic [WIDTH-1:0]   gpio_oe,
  output logic               irq
);
  logic [WIDTH-1:0] out_r, dir_r, rise_en, fall_en, status;
  logic [WIDTH-1:0] sync_v, rise_v, fall_v, wd, clr;
  logic [GPIO_DW-1:0] rd_mux;
  for (genvar i = 0; i < WIDTH; i++) begin : g_pin
    gpio_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_se (
      .clk(clk), .resetn(resetn), .d(gpio_in[i]),
      .sync(sync_v[i]), .rise(rise_v[i]), .fall(fall_v[i])
    );
  end
  assign wd  = wr_data[WIDTH-1:0];
  assign clr = (wr_en && addr == GPIO_ADDR_STATUS) ? wd : '0;
  always_comb begin
    rd_mux = addr == GPIO_ADDR_OUT     ? GPIO_DW'(out_r)   :
             addr == GPIO_ADDR_DIR     ? GPIO_DW'(dir_r)   :
             addr == GPIO_ADDR_IN      ? GPIO_DW'(sync_v)  :
             addr == GPIO_ADDR_RISE_EN ? GPIO_DW'(rise_en) :
             addr == GPIO_ADDR_FALL_EN ? GPIO_DW'(fall_en) :
             addr == GPIO_ADDR_STATUS  ? GPIO_DW'(status)  : '0;
  end
  always_ff @(posedge clk) begin
    if (!resetn) begin
      out_r   <= '0;
      dir_r   <= '0;
      rise_en <= '0;
      fall_en <= '0;
      status  <= '0;
      rd_data <= '0;
    end else begin
      if (wr_en && addr == GPIO_ADDR_OUT) out_r <= wd;
`ifdef GPIO_CTRL_SET_CLR_EN
      if (wr_en && addr == GPIO_ADDR_SET) out_r <= out_r | wd;
      if (wr_en && addr == GPIO_ADDR_CLR) out_r <= out_r & ~wd;
`endif
      if (wr_en && addr == GPIO_ADDR_DIR) dir_r <= wd;
      if (wr_en && addr == GPIO_ADDR_RISE_EN) rise_en <= wd;
      if (wr_en && addr == GPIO_ADDR_FALL_EN) fall_en <= wd;
      // new edges OR in after the clear so a same-cycle set survives
      status  <= (status & ~clr) | (rise_v & rise_en) | (fall_v & fall_en);
      rd_data <= rd_en ? rd_mux : '0;
    end
  end
  assign gpio_out = out_r;
  assign gpio_oe  = dir_r;
  assign irq      = |status;
endmodule

// File: tb/tb_gpio_ctrl.sv
// tb_gpio_ctrl: scoreboard bench for gpio_ctrl (WIDTH=32 main instance, WIDTH=8 companion)
module tb_gpio_ctrl;
  import gpio_ctrl_pkg::*;
  logic clk = 1'b0, resetn = 1'b0, wr_en = 1'b0, rd_en = 1'b0;
  logic [2:0] addr = '0;
  logic [31:0] wr_data = '0, gpio_in = '0;
  logic [31:0] gpio_out, gpio_oe, rd_data, rd_data8;
  logic [7:0] gpio_in8 = '0, gpio_out8, gpio_oe8;
  logic irq, irq8;
  int n_chk = 0, n_err = 0;
  logic [31:0] sb[$];
  logic [31:0] e;
`ifdef GPIO_CTRL_SET_CLR_EN
  localparam logic [31:0] EXP_SET = 32'hFF, EXP_CLR = 32'hC3;
`else
  localparam logic [31:0] EXP_SET = 32'h0F, EXP_CLR = 32'h0F;
`endif
  always #5 clk = ~clk;
  gpio_ctrl #(.WIDTH(32), .SYNC_STAGES(2)) dut (
    .clk(clk), .resetn(resetn), .wr_en(wr_en), .rd_en(rd_en), .addr(addr),
    .wr_data(wr_data), .rd_data(rd_data), .gpio_in(gpio_in),
    .gpio_out(gpio_out), .gpio_oe(gpio_oe), .irq(irq)
  );
  gpio_ctrl #(.WIDTH(8), .SYNC_STAGES(2)) dut8 (
    .clk(clk), .resetn(resetn), .wr_en(wr_en), .rd_en(rd_en), .addr(addr),
    .wr_data(wr_data), .rd_data(rd_data8), .gpio_in(gpio_in8),
    .gpio_out(gpio_out8), .gpio_oe(gpio_oe8), .irq(irq8)
  );
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    addr = a; wr_data = d; wr_en = 1'b1;
    tick();
    wr_en = 1'b0;
  endtask
  task automatic rd(input logic [2:0] a, input logic [31:0] exp);
    addr = a; rd_en = 1'b1;
    sb.push_back(exp);
    tick();
    rd_en = 1'b0;
  endtask
  task automatic test_reset;
    resetn = 1'b0; gpio_in = '1; gpio_in8 = '1;
    repeat (3) tick();
    addr = GPIO_ADDR_OUT; wr_data = '1; wr_en = 1'b1; rd_en = 1'b1;
    tick();
    wr_en = 1'b0; rd_en = 1'b0;
    n_chk++; if (gpio_out !== 32'h0) begin n_err++; $display("FAIL rst_out: got %h want %h", gpio_out, 32'h0); end
    n_chk++; if (gpio_oe !== 32'h0) begin n_err++; $display("FAIL rst_oe: got %h want %h", gpio_oe, 32'h0); end
    n_chk++; if (rd_data !== 32'h0) begin n_err++; $display("FAIL rst_rd: got %h want %h", rd_data, 32'h0); end
    resetn = 1'b1;
    repeat (4) tick();
    n_chk++; if (irq !== 1'b0) begin n_err++; $display("FAIL rst_irq: got %b want 0", irq); end
    rd(GPIO_ADDR_IN, 32'hFFFF_FFFF);
    e = sb.pop_front();
    n_chk++; if (rd_data !== e) begin n_err++; $display("FAIL rst_in: got %h want %h", rd_data, e); end
    rd(GPIO_ADDR_STATUS, 32'h0);
    e = sb.pop_front();
    n_chk++; if (rd_data !== e) begin n_err++; $display("FAIL rst_status: got %h want %h", rd_data, e); end
  endtask
  task automatic test_out_dir;
    wr(GPIO_ADDR_OUT, 32'hA5A5_A5A5);
    n_chk++; if (gpio_out !== 32'hA5A5_A5A5) begin n_err++; $display("FAIL gpio_out: got %h want %h", gpio_out, 32'hA5A5_A5A5); end
    wr(GPIO_ADDR_DIR, 32'h0000_FFFF);
    n_chk++; if (gpio_oe !== 32'h0000_FFFF) begin n_err++; $display("FAIL gpio_oe: got %h want %h", gpio_oe, 32'h0000_FFFF); end
    rd(GPIO_ADDR_OUT, 32'hA5A5_A5A5);
    e = sb.pop_front();
    n_chk++; if (rd_data !== e) begin n_err++; $display("FAIL rd_out: got %h want %h", rd_data, e); end
    rd(GPIO_ADDR_DIR, 32'h0000_FFFF);
    e = sb.pop_front();
    n_chk++; if (rd_data !== e) begin n_err++; $display("FAIL rd_dir: got %h want %h", rd_data, e); end
  endtask
  task automatic test_rise_irq;
    gpio_in = '0;
    repeat (4) tick();
    wr(GPIO_ADDR_RISE_EN, 32'h1);
    gpio_in[0] = 1'b1;
    tick(); tick();
    n_chk++; if (irq !== 1'b0) begin n_err++; $display("FAIL rise_early: got %b want 0", irq); end
    tick();
    n_chk++; if (irq !== 1'b1) begin n_err++; $display("FAIL rise_irq: got %b want 1", irq); end
    rd(GPIO_ADDR_STATUS, 32'h1);
    e = sb.pop_front();
    n_chk++; if (rd_data !== e) begin n_err++; $display("FAIL rise_status: got %h want %h", rd_data, e); end
    wr(GPIO_ADDR_STATUS, 32'h1);
    n_chk++; if (irq !== 1'b0) begin n_err++; $display("FAIL w1c_irq: got %b want 0", irq); end
  endtask
  task automatic test_fall_collision;
    gpio_in[1] = 1'b1;
    repeat (4) tick();
    n_chk++; if (irq !== 1'b0) begin n_err++; $display("FAIL rise_masked: got %b want 0", irq); end
    wr(GPIO_ADDR_FALL_EN, 32'h2);
    gpio_in[1] = 1'b0;
    tick(); tick();
    wr(GPIO_ADDR_STATUS, 32'h2);
    n_chk++; if (irq !== 1'b1) begin n_err++; $display("FAIL set_wins_irq: got %b want 1", irq); end
    wr(GPIO_ADDR_FALL_EN, 32'h0);
    rd(GPIO_ADDR_STATUS, 32'h2);
    e = sb.pop_front();
    n_chk++; if (rd_data !== e) begin n_err++; $display("FAIL set_wins_status: got %h want %h", rd_data, e); end
    wr(GPIO_ADDR_STATUS, 32'h2);
    n_chk++; if (irq !== 1'b0) begin n_err++; $display("FAIL fall_clear: got %b want 0", irq); end
  endtask
  task automatic test_rw_same_cycle;
    addr = GPIO_ADDR_OUT; wr_data = 32'h0F; wr_en = 1'b1; rd_en = 1'b1;
    sb.push_back(32'hA5A5_A5A5);
    tick();
    wr_en = 1'b0; rd_en = 1'b0;
    e = sb.pop_front();
    n_chk++; if (rd_data !== e) begin n_err++; $display("FAIL rw_old: got %h want %h", rd_data, e); end
    n_chk++; if (gpio_out !== 32'h0F) begin n_err++; $display("FAIL rw_new: got %h want %h", gpio_out, 32'h0F); end
  endtask
  task automatic test_set_clr;
    wr(GPIO_ADDR_SET, 32'hF0);
    rd(GPIO_ADDR_OUT, EXP_SET);
    e = sb.pop_front();
    n_chk++; if (rd_data !== e) begin n_err++; $display("FAIL set_out: got %h want %h", rd_data, e); end
    wr(GPIO_ADDR_CLR, 32'h3C);
    rd(GPIO_ADDR_OUT, EXP_CLR);
    e = sb.pop_front();
    n_chk++; if (rd_data !== e) begin n_err++; $display("FAIL clr_out: got %h want %h", rd_data, e); end
    wr(GPIO_ADDR_IN, 32'h1234_5678);
    rd(GPIO_ADDR_IN, 32'h1);
    e = sb.pop_front();
    n_chk++; if (rd_data !== e) begin n_err++; $display("FAIL ro_in: got %h want %h", rd_data, e); end
  endtask
  task automatic test_back_to_back;
    logic [2:0] a_tab[5];
    logic [31:0] e_tab[5];
    a_tab = '{GPIO_ADDR_OUT, GPIO_ADDR_DIR, GPIO_ADDR_RISE_EN, GPIO_ADDR_SET, GPIO_ADDR_CLR};
    e_tab = '{EXP_CLR, 32'h0000_FFFF, 32'h1, 32'h0, 32'h0};
    for (int i = 0; i < 5; i++) begin
      addr = a_tab[i]; rd_en = 1'b1;
      sb.push_back(e_tab[i]);
      tick();
      e = sb.pop_front();
      n_chk++; if (rd_data !== e) begin n_err++; $display("FAIL b2b_rd%0d: got %h want %h", i, rd_data, e); end
    end
    rd_en = 1'b0;
    tick();
    n_chk++; if (rd_data !== 32'h0) begin n_err++; $display("FAIL rd_idle: got %h want %h", rd_data, 32'h0); end
  endtask
  task automatic test_width8;
    wr(GPIO_ADDR_OUT, 32'hFFFF_FFFF);
    n_chk++; if (gpio_out8 !== 8'hFF) begin n_err++; $display("FAIL w8_out: got %h want %h", gpio_out8, 8'hFF); end
    rd(GPIO_ADDR_OUT, 32'h0000_00FF);
    e = sb.pop_front();
    n_chk++; if (rd_data8 !== e) begin n_err++; $display("FAIL w8_rd: got %h want %h", rd_data8, e); end
    rd(GPIO_ADDR_IN, 32'h0000_00FF);
    e = sb.pop_front();
    n_chk++; if (rd_data8 !== e) begin n_err++; $display("FAIL w8_in: got %h want %h", rd_data8, e); end
  endtask
  initial begin
    test_reset();
    test_out_dir();
    test_rise_irq();
    test_fall_collision();
    test_rw_same_cycle();
    test_set_clr();
    test_back_to_back();
    test_width8();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
